// File: rtl/pt_pkg.sv
// pt_pkg: shared types and constants for the page table walk controller
package pt_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} pw_state_t;
    localparam int PT_VPN_W = 6;
    localparam int PT_PPN_W = 2;
    localparam int ITLB = 0;
    localparam int DTLB = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester that did not win last time is granted
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    assign grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/page_walk_ctrl.sv
// page_walk_ctrl: arbitrates ITLB/DTLB requests and runs one page table command at a time
// with a WAIT timeout; all outputs come straight from registers.
module page_walk_ctrl
    import pt_pkg::*;
#(
    parameter int VPN_W   = PT_VPN_W,
    parameter int PPN_W   = PT_PPN_W,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_write,
    input  logic [2*VPN_W-1:0] req_vpn,
    input  logic [2*PPN_W-1:0] req_ppn,
    output logic [1:0]         resp_valid,
    output logic [PPN_W-1:0]   resp_ppn,
    output logic               resp_fault,
    output logic               resp_err,
    output logic               pt_req,
    output logic               pt_write,
    output logic [VPN_W-1:0]   pt_vpn,
    output logic [PPN_W-1:0]   pt_ppn,
    input  logic               pt_done,
    input  logic               pt_fault,
    input  logic [PPN_W-1:0]   pt_ppn_rd,
    output logic               busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    pw_state_t        r_state, w_next;
    logic [1:0]       w_gnt, r_gnt, r_resp_valid;
    logic             r_last, r_write, r_pt_req, r_busy, r_fault, r_err;
    logic [VPN_W-1:0] r_vpn;
    logic [PPN_W-1:0] r_ppn, r_resp_ppn;
    logic [TW-1:0]    r_timer;
    logic             w_timeout, w_to_resp, w_take;

    rr_arb2 u_arb (.req(req_valid), .last(r_last), .grant(w_gnt));

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;

    // The timer counts completed WAIT cycles, so leaving at TIMEOUT-1 gives exactly TIMEOUT WAIT cycles
    assign w_timeout = r_timer == TW'(TIMEOUT - 1);

    always_comb begin
        w_next = (r_state == S_IDLE)  ? ((|req_valid) ? S_ISSUE : S_IDLE) :
                 (r_state == S_ISSUE) ? S_WAIT :
                 (r_state == S_WAIT)  ? ((pt_done || w_timeout) ? S_RESP : S_WAIT) : S_IDLE;
    end

    always_comb begin
        w_to_resp = (r_state == S_WAIT) && (w_next == S_RESP);
        w_take    = w_to_resp && pt_done && !r_write;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt        <= '0;
            r_last       <= 1'b1;
            r_write      <= 1'b0;
            r_vpn        <= '0;
            r_ppn        <= '0;
            r_timer      <= '0;
            r_pt_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= '0;
            r_resp_ppn   <= '0;
            r_fault      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == S_IDLE && |req_valid) begin
                r_gnt   <= w_gnt;
                r_write <= req_write[w_gnt[DTLB]];
                r_vpn   <= w_gnt[DTLB] ? req_vpn[DTLB*VPN_W +: VPN_W] : req_vpn[ITLB*VPN_W +: VPN_W];
                r_ppn   <= w_gnt[DTLB] ? req_ppn[DTLB*PPN_W +: PPN_W] : req_ppn[ITLB*PPN_W +: PPN_W];
            end
            if (r_state == S_RESP) r_last <= r_gnt[DTLB];
            r_timer      <= (r_state == S_WAIT) ? r_timer + 1'b1 : '0;
            r_pt_req     <= w_next == S_ISSUE;
            r_busy       <= w_next != S_IDLE;
            r_resp_valid <= w_to_resp ? r_gnt : 2'b00;
            r_resp_ppn   <= w_take ? pt_ppn_rd : '0;
            r_fault      <= w_take && pt_fault;
            r_err        <= w_to_resp && !pt_done;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_ppn   = r_resp_ppn;
    assign resp_fault = r_fault;
    assign resp_err   = r_err;
    assign pt_req     = r_pt_req;
    assign pt_write   = r_write;
    assign pt_vpn     = r_vpn;
    assign pt_ppn     = r_ppn;
    assign busy       = r_busy;
endmodule

// File: tb/tb_page_walk_ctrl.sv
// tb_page_walk_ctrl: scoreboard bench for page_walk_ctrl
module tb_page_walk_ctrl;
    typedef struct {
        logic [1:0] gnt;
        logic [1:0] ppn;
        logic       flt;
        logic       err;
    } exp_t;

    logic        clk, reset;
    logic [1:0]  req_valid, req_write;
    logic [11:0] req_vpn;
    logic [3:0]  req_ppn;
    logic [1:0]  resp_valid, resp_ppn, pt_ppn, pt_ppn_rd;
    logic        resp_fault, resp_err, pt_req, pt_write, pt_done, pt_fault, busy;
    logic [5:0]  pt_vpn;

    exp_t sb[$];
    exp_t e_mon;
    int   n_chk, n_fail;

    page_walk_ctrl #(.VPN_W(6), .PPN_W(2), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_vpn(req_vpn), .req_ppn(req_ppn), .resp_valid(resp_valid), .resp_ppn(resp_ppn),
        .resp_fault(resp_fault), .resp_err(resp_err), .pt_req(pt_req), .pt_write(pt_write),
        .pt_vpn(pt_vpn), .pt_ppn(pt_ppn), .pt_done(pt_done), .pt_fault(pt_fault),
        .pt_ppn_rd(pt_ppn_rd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid != 2'b00) begin
            if (sb.size() == 0) check("unexpected_resp", {30'd0, resp_valid}, 32'd0);
            else begin
                e_mon = sb.pop_front();
                check("resp_valid", {30'd0, resp_valid}, {30'd0, e_mon.gnt});
                check("resp_ppn", {30'd0, resp_ppn}, {30'd0, e_mon.ppn});
                check("resp_fault", {31'd0, resp_fault}, {31'd0, e_mon.flt});
                check("resp_err", {31'd0, resp_err}, {31'd0, e_mon.err});
            end
        end
    end

    // One transaction; the request is dropped after the grant cycle and must still complete
    task automatic txn(input int r, input bit wr, input logic [5:0] vpn, input logic [1:0] ppn,
                       input int dly, input bit flt, input logic [1:0] rd, input bit to, input bit spur);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_valid = 2'b00; req_valid[r] = 1'b1;
        req_write = 2'b00; req_write[r] = wr;
        req_vpn = '0; req_vpn[r*6 +: 6] = vpn;
        req_ppn = '0; req_ppn[r*2 +: 2] = ppn;
        sb.push_back('{gnt: 2'(1 << r), ppn: (to || wr) ? 2'd0 : rd,
                       flt: (to || wr) ? 1'b0 : flt, err: to});
        @(negedge clk);
        check("busy_grant_cycle", {31'd0, busy}, 32'd0);
        for (int c = 1; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            req_valid = 2'b00;
            pt_done   = (!to && c == 2 + dly) || (spur && c == 1);
            pt_fault  = flt;
            pt_ppn_rd = rd;
            @(negedge clk);
            if (c == 1) begin
                check("pt_req", {31'd0, pt_req}, 32'd1);
                check("pt_write", {31'd0, pt_write}, {31'd0, wr});
                check("pt_vpn", {26'd0, pt_vpn}, {26'd0, vpn});
                check("pt_ppn", {30'd0, pt_ppn}, {30'd0, ppn});
                check("busy", {31'd0, busy}, 32'd1);
            end
            if (c == 2) check("pt_req_one_cycle", {31'd0, pt_req}, 32'd0);
            if (resp_valid != 2'b00) begin
                check("latency", c, to ? 32'd17 : 32'(3 + dly));
                got = 1;
            end
        end
        if (!got) check("resp_never_came", 32'd0, 32'd1);
        @(posedge clk); #1;
        pt_done = 1'b0;
        @(negedge clk);
        check("busy_after_resp", {31'd0, busy}, 32'd0);
        check("resp_one_cycle", {30'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int n, k;
        n_chk = 0; n_fail = 0;
        reset = 1'b1; req_valid = '0; req_write = '0; req_vpn = '0; req_ppn = '0;
        pt_done = 1'b0; pt_fault = 1'b0; pt_ppn_rd = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {resp_valid, resp_ppn, resp_fault, resp_err, pt_req, pt_write,
                                pt_vpn, pt_ppn, busy}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Simultaneous held requests with pt_done stuck high: r0 first, then alternation
        @(posedge clk); #1;
        req_valid = 2'b11; req_write = 2'b00; req_vpn = {6'd7, 6'd0}; req_ppn = '0;
        pt_done = 1'b1; pt_fault = 1'b0; pt_ppn_rd = 2'd1;
        for (int i = 0; i < 4; i++) sb.push_back('{gnt: i[0] ? 2'b10 : 2'b01, ppn: 2'd1, flt: 1'b0, err: 1'b0});
        n = 0; k = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (pt_req) begin
                check("rr_vpn", {26'd0, pt_vpn}, k[0] ? 32'd7 : 32'd0);
                k++;
            end
            if (resp_valid != 2'b00) n++;
        end
        @(posedge clk); #1;
        req_valid = 2'b00; pt_done = 1'b0;
        check("rr_count", n, 32'd4);
        @(negedge clk);
        check("rr_idle", {31'd0, busy}, 32'd0);

        txn(0, 0, 6'd4,  2'd0, 0,  0, 2'd2, 0, 0);
        txn(1, 0, 6'h3f, 2'd0, 3,  0, 2'd1, 0, 1);
        txn(0, 0, 6'd10, 2'd0, 14, 0, 2'd3, 0, 0);
        txn(1, 0, 6'd2,  2'd0, 0,  1, 2'd0, 0, 0);
        txn(1, 1, 6'd8,  2'd3, 0,  1, 2'd2, 0, 0);
        txn(0, 0, 6'd5,  2'd0, 0,  0, 2'd1, 1, 0);

        // pt_done while idle must be ignored
        @(posedge clk); #1 pt_done = 1'b1;
        @(posedge clk); #1 pt_done = 1'b0;
        @(negedge clk);
        check("idle_pt_done_busy", {31'd0, busy}, 32'd0);

        // Reset in WAIT discards the transaction; a late pt_done yields nothing
        @(posedge clk); #1;
        req_valid = 2'b01; req_write = 2'b00; req_vpn = {6'd0, 6'd9};
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #1;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_wait_outs", {30'd0, busy, pt_req, resp_valid, pt_vpn}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 pt_done = 1'b1;
        @(posedge clk); #1 pt_done = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid != 2'b00 || busy) n++;
        end
        check("late_pt_done_ignored", n, 32'd0);

        txn(1, 0, 6'd33, 2'd0, 1, 0, 2'd3, 0, 0);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
